counter_modn: RTL and testbench
===============================

COUNTER_MODN -- requirements
Module: counter_modn

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and modulus width in bits.
REQ-002 SHALL have parameter DEF_MOD, default 6, modulus used when mod_sel=0.
REQ-003 in_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous clear.
REQ-006 load  input  1  synchronous load of load_val.
REQ-007 load_val  input  WIDTH  value to load.
REQ-008 en  input  1  count enable; also the cascade carry-in.
REQ-009 dir  input  1  0=count up, 1=count down.
REQ-010 mod_sel  input  1  0=use DEF_MOD, 1=use mod_val.
REQ-011 mod_val  input  WIDTH  runtime modulus.
REQ-012 q  output  WIDTH  current count, registered.
REQ-013 carry_out  output  1  combinational wrap indication for cascading.
REQ-014 out_clk  output  1  registered divided clock, toggles on every wrap.

Function
REQ-015 Effective modulus M SHALL be DEF_MOD or mod_val per mod_sel; value 0 SHALL mean 2^WIDTH.
REQ-016 Per-edge priority SHALL be clr > load > en > hold.
REQ-017 clr SHALL set q=0 and out_clk=0.
REQ-018 load SHALL set q=load_val if load_val<M, else q=0; out_clk SHALL be unchanged.
REQ-019 Up, en=1: q<M-1 -> q+1; q>=M-1 -> q=0 (wrap).
REQ-020 Down, en=1: 0<q<M -> q-1; q=0 -> q=M-1 (wrap); q>=M -> q=M-1, no wrap.
REQ-021 carry_out SHALL be en & ~clr & ~load & (wrap condition of REQ-019/020) in the same cycle, zero latency.
REQ-022 out_clk SHALL toggle on every edge where carry_out=1, giving a period of 2*M in_clk cycles at constant en=1.
REQ-023 M=1 SHALL hold q=0 with carry_out=en on every enabled cycle.
REQ-024 A change to mod_val or dir SHALL take effect on the next edge, with no extra pipeline stage.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with no overflow beyond WIDTH bits.

Reset
REQ-026 rst low SHALL asynchronously force q=0 and out_clk=0; carry_out SHALL be 0 while rst is low.
REQ-027 Release of rst SHALL leave the counter idle until the first enabled edge; reset asserted mid-count SHALL abandon the count with no wrap or toggle.

Configuration
REQ-028 Macro COUNTER_MODN_DOWN_EN SHALL compile in down-count support per REQ-020.
REQ-029 Without COUNTER_MODN_DOWN_EN, the dir port SHALL remain present but be ignored, and counting SHALL be up-only.

Structure
REQ-030 Shared package counter_pkg SHALL hold the WIDTH/DEF_MOD defaults and the dir encodings DIR_UP=0 and DIR_DOWN=1.
REQ-031 Next-count and wrap logic SHALL live in one combinational sub-module, counter_modn_next; the top level holds only the registers.

Verification
REQ-032 Reset, then en=1, dir=0, mod_sel=0 (M=6) for 24 cycles -> q 0,1,..,5,0,...; carry_out high at q=5; out_clk toggles every 6 cycles (period 12).
REQ-033 mod_sel=1, mod_val=10, dir=1 from q=0 -> q 9,8,..,0,9; carry_out high on the cycle q=0.
REQ-034 load=1, load_val=3 with en=1 and M=6 -> q=3, no carry_out, no out_clk toggle; repeat with load_val=7 -> q=0.
REQ-035 clr and load together at q=4 -> q=0, out_clk=0; mod_val=0 with WIDTH=4 -> wraps 15->0 with carry_out.
REQ-036 Two instances cascaded (carry_out of first to en of second), M=10 and M=6 -> second instance increments once per 10 cycles; rst pulsed mid-count -> both instances at q=0 immediately, with no spurious toggle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared defaults and encodings for the modulo-N counter.
// Down counting is compiled in only with COUNTER_MODN_DOWN_EN.
package counter_pkg;

   localparam int CNT_WIDTH   = 4;
   localparam int CNT_DEF_MOD = 6;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_COUNT,
      OP_LOAD,
      OP_CLR
   } op_e;

endpackage

// File: rtl/counter_modn_if.sv
// Control and status bundle of the modulo-N counter.
// The counter is the slave; whoever drives controls is the master.
interface counter_modn_if
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
);

   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             dir;
   logic             mod_sel;
   logic [WIDTH-1:0] mod_val;
   logic [WIDTH-1:0] q;
   logic             carry_out;
   logic             out_clk;

   modport master (
      output clr, load, load_val, en, dir, mod_sel, mod_val,
      input  q, carry_out, out_clk
   );

   modport slave (
      input  clr, load, load_val, en, dir, mod_sel, mod_val,
      output q, carry_out, out_clk
   );

endinterface

// File: rtl/counter_modn_next.sv
// Next-count, wrap and divided-clock logic of the modulo-N counter.
// Down counting is present only with COUNTER_MODN_DOWN_EN defined.
module counter_modn_next
   import counter_pkg::*;
#(
   parameter int WIDTH   = CNT_WIDTH,
   parameter int DEF_MOD = CNT_DEF_MOD
) (
   input  logic             rst,
   input  logic [WIDTH-1:0] q,
   input  logic             out_clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   input  logic             mod_sel,
   input  logic [WIDTH-1:0] mod_val,
   output logic [WIDTH-1:0] q_nxt,
   output logic             out_clk_nxt,
   output logic             carry_out
);

   localparam logic [WIDTH-1:0] DEF_M = WIDTH'(DEF_MOD);

   logic [WIDTH-1:0] m_sel;
   logic [WIDTH-1:0] last;
   logic [WIDTH-1:0] cnt_nxt;
   logic             cnt_wrap;
   logic             in_range;
   logic             ld_ok;
   logic             wrap;
   op_e              op;

   assign m_sel = mod_sel ? mod_val : DEF_M;
   assign last  = m_sel - WIDTH'(1);

   // a zero modulus stands for 2^WIDTH: every value is in range
   assign in_range = (m_sel == '0) || (q < m_sel);
   assign ld_ok    = (m_sel == '0) || (load_val < m_sel);

`ifdef COUNTER_MODN_DOWN_EN
   always_comb begin
      cnt_nxt  = q;
      cnt_wrap = 1'b0;
      if (dir == DIR_DOWN) begin
         if (q == '0) begin
            cnt_nxt  = last;
            cnt_wrap = 1'b1;
         end else if (in_range) begin
            cnt_nxt = q - WIDTH'(1);
         end else begin
            cnt_nxt = last;
         end
      end else if (q >= last) begin
         cnt_nxt  = '0;
         cnt_wrap = 1'b1;
      end else begin
         cnt_nxt = q + WIDTH'(1);
      end
   end
`else
   logic unused_dir;
   logic unused_range;

   assign unused_dir   = dir;
   assign unused_range = in_range;

   always_comb begin
      cnt_nxt  = q + WIDTH'(1);
      cnt_wrap = 1'b0;
      if (q >= last) begin
         cnt_nxt  = '0;
         cnt_wrap = 1'b1;
      end
   end
`endif

   always_comb begin
      op = OP_HOLD;
      unique case (1'b1)
         clr:                   op = OP_CLR;
         (!clr && load):        op = OP_LOAD;
         (!clr && !load && en): op = OP_COUNT;
         default:               op = OP_HOLD;
      endcase
   end

   always_comb begin
      q_nxt       = q;
      out_clk_nxt = out_clk;
      wrap        = 1'b0;
      unique case (op)
         OP_CLR: begin
            q_nxt       = '0;
            out_clk_nxt = 1'b0;
         end
         OP_LOAD: begin
            q_nxt = ld_ok ? load_val : '0;
         end
         OP_COUNT: begin
            q_nxt       = cnt_nxt;
            wrap        = cnt_wrap;
            out_clk_nxt = out_clk ^ cnt_wrap;
         end
         default: begin
            q_nxt = q;
         end
      endcase
   end

   assign carry_out = wrap & rst;

endmodule

// File: rtl/counter_modn.sv
// Modulo-N up/down counter with cascade carry and divided clock.
// Build with COUNTER_MODN_DOWN_EN to enable down counting.
module counter_modn
   import counter_pkg::*;
#(
   parameter int WIDTH   = CNT_WIDTH,
   parameter int DEF_MOD = CNT_DEF_MOD
) (
   input logic           in_clk,
   input logic           rst,
   counter_modn_if.slave bus
);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic             out_clk_r;
   logic             out_clk_nxt;
   logic             carry;

   counter_modn_next #(
      .WIDTH   (WIDTH),
      .DEF_MOD (DEF_MOD)
   ) u_next (
      .rst         (rst),
      .q           (q_r),
      .out_clk     (out_clk_r),
      .clr         (bus.clr),
      .load        (bus.load),
      .load_val    (bus.load_val),
      .en          (bus.en),
      .dir         (bus.dir),
      .mod_sel     (bus.mod_sel),
      .mod_val     (bus.mod_val),
      .q_nxt       (q_nxt),
      .out_clk_nxt (out_clk_nxt),
      .carry_out   (carry)
   );

   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         q_r       <= '0;
         out_clk_r <= 1'b0;
      end else begin
         q_r       <= q_nxt;
         out_clk_r <= out_clk_nxt;
      end
   end

   assign bus.q         = q_r;
   assign bus.out_clk   = out_clk_r;
   assign bus.carry_out = carry;

endmodule

// File: tb/tb_counter_modn.sv
// Directed bench for counter_modn, including a two-stage cascade.
// Down-count vectors run when COUNTER_MODN_DOWN_EN is defined.
module tb_counter_modn;

   logic in_clk = 1'b0;
   logic rst    = 1'b1;
   int   total  = 0;
   int   bad    = 0;
   logic exp_oc = 1'b0;

   int ld_v [4] = '{3, 7, 5, 6};
   int ld_q [4] = '{3, 0, 5, 0};

   always #5 in_clk = ~in_clk;

   counter_modn_if #(.WIDTH(4)) a_if ();
   counter_modn_if #(.WIDTH(4)) b_if ();
   counter_modn_if #(.WIDTH(4)) c_if ();

   counter_modn #(.WIDTH(4), .DEF_MOD(6)) u_dut (
      .in_clk (in_clk),
      .rst    (rst),
      .bus    (a_if)
   );

   counter_modn #(.WIDTH(4), .DEF_MOD(10)) u_lo (
      .in_clk (in_clk),
      .rst    (rst),
      .bus    (b_if)
   );

   counter_modn #(.WIDTH(4), .DEF_MOD(6)) u_hi (
      .in_clk (in_clk),
      .rst    (rst),
      .bus    (c_if)
   );

   assign c_if.en = b_if.carry_out;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic tick(input string tag, input logic exp_c, input int exp_q);
      #1;
      chk({tag, "_co"}, int'(a_if.carry_out), int'(exp_c));
      step();
      exp_oc = exp_oc ^ exp_c;
      chk({tag, "_q"}, int'(a_if.q), exp_q);
      chk({tag, "_oclk"}, int'(a_if.out_clk), int'(exp_oc));
   endtask

   task automatic clear();
      a_if.clr = 1'b1;
      exp_oc   = 1'b0;
      tick("clr", 1'b0, 0);
      a_if.clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int   eq;
      int   nq;
      logic c;

      a_if.clr = 0; a_if.load = 0; a_if.load_val = 0; a_if.en = 0;
      a_if.dir = 0; a_if.mod_sel = 0; a_if.mod_val = 0;
      b_if.clr = 0; b_if.load = 0; b_if.load_val = 0; b_if.en = 0;
      b_if.dir = 0; b_if.mod_sel = 0; b_if.mod_val = 0;
      c_if.clr = 0; c_if.load = 0; c_if.load_val = 0;
      c_if.dir = 0; c_if.mod_sel = 0; c_if.mod_val = 0;

      // reset held, M=1 and en=1 would otherwise wrap
      #1 rst = 1'b0;
      a_if.en = 1; a_if.mod_sel = 1; a_if.mod_val = 4'd1;
      #1;
      chk("rst_co", int'(a_if.carry_out), 0);
      chk("rst_q", int'(a_if.q), 0);
      chk("rst_oclk", int'(a_if.out_clk), 0);
      a_if.en = 0; a_if.mod_sel = 0; a_if.mod_val = 0;
      @(negedge in_clk);
      rst = 1'b1;
      step();
      chk("idle_q", int'(a_if.q), 0);

      a_if.en = 1;
      eq = 0;
      for (int i = 0; i < 24; i++) begin
         c  = (eq == 5);
         nq = c ? 0 : eq + 1;
         tick("up6", c, nq);
         eq = nq;
      end

      for (int v = 1; v <= 5; v++) tick("pre_ld", 1'b0, v);
      a_if.load = 1;
      for (int i = 0; i < 4; i++) begin
         a_if.load_val = 4'(ld_v[i]);
         tick("ld", 1'b0, ld_q[i]);
      end
      a_if.load = 0;

      eq = 0;
      for (int i = 0; i < 10; i++) begin
         c  = (eq == 5);
         nq = c ? 0 : eq + 1;
         tick("run", c, nq);
         eq = nq;
      end
      a_if.clr = 1; a_if.load = 1; a_if.load_val = 4'd2;
      exp_oc = 1'b0;
      tick("clr_ld", 1'b0, 0);
      a_if.clr = 0; a_if.load = 0;

      a_if.mod_sel = 1; a_if.mod_val = 4'd0;
      for (int v = 1; v <= 15; v++) tick("m0", 1'b0, v);
      tick("m0_wrap", 1'b1, 0);

      a_if.mod_val = 4'd1;
      tick("m1", 1'b1, 0);
      tick("m1", 1'b1, 0);
      a_if.en = 0;
      tick("m1_off", 1'b0, 0);
      a_if.en = 1;

      a_if.mod_val = 4'd10;
      for (int v = 1; v <= 7; v++) tick("m10", 1'b0, v);
      a_if.mod_val = 4'd8;
      tick("mod_chg", 1'b1, 0);
      a_if.mod_val = 4'd10;
      for (int v = 1; v <= 9; v++) tick("m10b", 1'b0, v);
      a_if.mod_val = 4'd4;
      tick("over_m", 1'b1, 0);

      clear();
      a_if.mod_val = 4'd10;
      a_if.dir = 1;
`ifdef COUNTER_MODN_DOWN_EN
      tick("dn_wrap", 1'b1, 9);
      for (int v = 8; v >= 0; v--) tick("dn", 1'b0, v);
      tick("dn_wrap2", 1'b1, 9);
      a_if.mod_val = 4'd5;
      tick("dn_over", 1'b0, 4);
`else
      tick("dir_ign", 1'b0, 1);
      tick("dir_ign", 1'b0, 2);
`endif
      a_if.dir = 0;
      a_if.en = 0;
      clear();

      b_if.en = 1;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (k == 9) begin
            chk("cas9_lo", int'(b_if.q), 9);
            chk("cas9_hi", int'(c_if.q), 0);
         end
         if (k == 10) begin
            chk("cas10_lo", int'(b_if.q), 0);
            chk("cas10_hi", int'(c_if.q), 1);
         end
      end
      chk("cas15_lo", int'(b_if.q), 5);
      chk("cas15_hi", int'(c_if.q), 1);
      chk("cas15_oclk", int'(b_if.out_clk), 1);

      #2 rst = 1'b0;
      #1;
      chk("arst_lo", int'(b_if.q), 0);
      chk("arst_hi", int'(c_if.q), 0);
      chk("arst_lo_oclk", int'(b_if.out_clk), 0);
      chk("arst_hi_oclk", int'(c_if.out_clk), 0);
      chk("arst_co", int'(b_if.carry_out), 0);
      b_if.en = 0;
      step();
      step();
      chk("rsthold_lo", int'(b_if.q), 0);
      @(negedge in_clk);
      rst = 1'b1;
      step();
      chk("post_lo", int'(b_if.q), 0);
      chk("post_hi", int'(c_if.q), 0);
      chk("post_lo_oclk", int'(b_if.out_clk), 0);
      chk("post_hi_oclk", int'(c_if.out_clk), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
